// File: rtl/get_const_arbiter.sv
// Round-robin arbiter that shares one 8-entry constant table between NREQ requesters.
// Winning lookups are captured into a single output slot that drains through a valid/ready channel.
module get_const_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned TAGW = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [3*NREQ-1:0]    req_sel,
    input  logic [TAGW*NREQ-1:0] req_tag,
    output logic [NREQ-1:0]      req_ready,
    output logic [2:0]           lut_sel,
    input  logic [7:0]           lut_data,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [7:0]           rsp_data,
    output logic [IDW-1:0]       rsp_id,
    output logic [TAGW-1:0]      rsp_tag,
    output logic [15:0]          grant_cnt
);

    localparam int unsigned PW = IDW + 1;

    typedef enum logic {StEmpty, StFull} slot_e;

    slot_e           state_q, state_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]  win;
    logic [PW-1:0]   win_sum, ptr_sum;
    logic            any_valid, slot_free, accept;
    logic [2*NREQ-1:0] rot;
    logic [2:0]      sel_w, lut_sel_q;
    logic [TAGW-1:0] tag_w, rsp_tag_q;
    logic [7:0]      rsp_data_q;
    logic [IDW-1:0]  rsp_id_q;
    logic [15:0]     grant_cnt_q;

    // Rotate so that bit 0 is the requester at rr_ptr; the first set bit is the winner.
    always_comb begin
        rot       = {req_valid, req_valid} >> rr_ptr_q;
        any_valid = 1'b0;
        win_sum   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!any_valid && rot[k]) begin
                any_valid = 1'b1;
                win_sum   = {1'b0, rr_ptr_q} + PW'(k);
            end
        end
        if (win_sum >= PW'(NREQ)) begin
            win_sum = win_sum - PW'(NREQ);
        end
        win = win_sum[IDW-1:0];
    end

    always_comb begin
        sel_w = '0;
        tag_w = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == IDW'(i)) begin
                sel_w = req_sel[3*i +: 3];
                tag_w = req_tag[TAGW*i +: TAGW];
            end
        end
    end

    assign slot_free = (state_q == StEmpty) || rsp_ready;
    assign accept    = any_valid && slot_free;
    assign lut_sel   = any_valid ? sel_w : lut_sel_q;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = rst_n && accept && (win == IDW'(i));
        end
    end

    always_comb begin
        ptr_sum  = {1'b0, win} + PW'(1);
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = (ptr_sum >= PW'(NREQ)) ? '0 : ptr_sum[IDW-1:0];
        end
    end

    // Slot state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    // Slot next state: a refill wins over a drain in the same cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEmpty: if (accept) state_d = StFull;
            StFull: begin
                if (accept) begin
                    state_d = StFull;
                end else if (rsp_ready) begin
                    state_d = StEmpty;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    // Slot outputs.
    always_comb begin
        rsp_valid = (state_q == StFull);
        rsp_data  = rsp_data_q;
        rsp_id    = rsp_id_q;
        rsp_tag   = rsp_tag_q;
        grant_cnt = grant_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            lut_sel_q   <= '0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            rsp_tag_q   <= '0;
            grant_cnt_q <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            lut_sel_q <= lut_sel;
            if (accept) begin
                rsp_data_q <= lut_data;
                rsp_id_q   <= win;
                rsp_tag_q  <= tag_w;
                if (grant_cnt_q != 16'hFFFF) begin
                    grant_cnt_q <= grant_cnt_q + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_get_const_arbiter.sv
// Directed bench for get_const_arbiter: round-robin order, backpressure, reset and count saturation.
// The bench supplies the constant table the arbiter indexes.
module tb_get_const_arbiter;

    localparam int unsigned NREQ = 2;
    localparam int unsigned TAGW = 4;
    localparam int unsigned IDW  = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [3*NREQ-1:0]    req_sel;
    logic [TAGW*NREQ-1:0] req_tag;
    logic [NREQ-1:0]      req_ready;
    logic [2:0]           lut_sel;
    logic [7:0]           lut_data;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [7:0]           rsp_data;
    logic [IDW-1:0]       rsp_id;
    logic [TAGW-1:0]      rsp_tag;
    logic [15:0]          grant_cnt;

    int n_checks = 0;
    int n_errors = 0;

    get_const_arbiter #(.NREQ(NREQ), .TAGW(TAGW), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_sel   (req_sel),
        .req_tag   (req_tag),
        .req_ready (req_ready),
        .lut_sel   (lut_sel),
        .lut_data  (lut_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_tag   (rsp_tag),
        .grant_cnt (grant_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] lut_fn(input logic [2:0] s);
        case (s)
            3'd0: lut_fn = 8'd0;
            3'd1: lut_fn = 8'd1;
            3'd2: lut_fn = 8'd200;
            3'd3: lut_fn = 8'd204;
            3'd4: lut_fn = 8'd4;
            3'd5: lut_fn = 8'd3;
            3'd6: lut_fn = 8'd128;
            default: lut_fn = 8'd32;
        endcase
    endfunction

    assign lut_data = lut_fn(lut_sel);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [2:0] s, input logic [TAGW-1:0] t);
        req_sel[3*i +: 3]       = s;
        req_tag[TAGW*i +: TAGW] = t;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    logic [7:0] sweep_exp [8] = '{8'd0, 8'd1, 8'd200, 8'd204, 8'd4, 8'd3, 8'd128, 8'd32};
    logic [7:0] alt_data  [4] = '{8'd204, 8'd32, 8'd204, 8'd32};

    initial begin
        rst_n     = 1'b0;
        req_valid = 2'b11;
        req_sel   = '0;
        req_tag   = '0;
        rsp_ready = 1'b0;
        #2;
        check_eq("rst_ready", 32'(req_ready), 32'd0);
        step();
        check_eq("rst_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_data", 32'(rsp_data), 32'd0);
        check_eq("rst_cnt", 32'(grant_cnt), 32'd0);
        req_valid = '0;
        rst_n     = 1'b1;
        step();

        // Single request from requester 0.
        set_req(0, 3'b010, 4'd5);
        req_valid = 2'b01;
        #1;
        check_eq("t1_ready", 32'(req_ready), 32'b01);
        check_eq("t1_lutsel", 32'(lut_sel), 32'd2);
        step();
        req_valid = '0;
        check_eq("t1_valid", 32'(rsp_valid), 32'd1);
        check_eq("t1_data", 32'(rsp_data), 32'd200);
        check_eq("t1_id", 32'(rsp_id), 32'd0);
        check_eq("t1_tag", 32'(rsp_tag), 32'd5);
        check_eq("t1_cnt", 32'(grant_cnt), 32'd1);
        rsp_ready = 1'b1;
        step();
        check_eq("t1_drain", 32'(rsp_valid), 32'd0);

        // Both requesters continuously valid after reset: strict alternation.
        do_reset();
        set_req(0, 3'b011, 4'd1);
        set_req(1, 3'b111, 4'd2);
        req_valid = 2'b11;
        for (int n = 0; n < 4; n++) begin
            step();
            check_eq("t2_valid", 32'(rsp_valid), 32'd1);
            check_eq("t2_id", 32'(rsp_id), 32'(n % 2));
            check_eq("t2_data", 32'(rsp_data), 32'(alt_data[n]));
        end
        check_eq("t2_cnt", 32'(grant_cnt), 32'd4);
        req_valid = '0;
        step();
        check_eq("t2_drain", 32'(rsp_valid), 32'd0);

        // Backpressure holds the slot and blocks new accepts.
        rsp_ready = 1'b0;
        set_req(0, 3'b110, 4'd3);
        req_valid = 2'b01;
        step();
        set_req(0, 3'b001, 4'd9);
        for (int n = 0; n < 3; n++) begin
            check_eq("t3_ready", 32'(req_ready), 32'd0);
            check_eq("t3_data", 32'(rsp_data), 32'd128);
            check_eq("t3_tag", 32'(rsp_tag), 32'd3);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        check_eq("t3_ready_rise", 32'(req_ready), 32'b01);
        step();
        check_eq("t3_next_data", 32'(rsp_data), 32'd1);
        check_eq("t3_next_tag", 32'(rsp_tag), 32'd9);
        check_eq("t3_cnt", 32'(grant_cnt), 32'd6);
        req_valid = '0;
        step();

        // Sweep every table entry from requester 1.
        req_valid = 2'b10;
        for (int s = 0; s < 8; s++) begin
            set_req(1, 3'(s), 4'(s));
            step();
            check_eq("t4_data", 32'(rsp_data), 32'(sweep_exp[s]));
            check_eq("t4_id", 32'(rsp_id), 32'd1);
        end
        req_valid = '0;
        step();
        check_eq("t4_lutsel_hold", 32'(lut_sel), 32'd7);
        check_eq("t4_cnt", 32'(grant_cnt), 32'd14);

        // Reset while a response is pending and requests are waiting.
        rsp_ready = 1'b0;
        set_req(0, 3'b000, 4'd1);
        set_req(1, 3'b011, 4'd2);
        req_valid = 2'b01;
        step();
        check_eq("t5_pre_valid", 32'(rsp_valid), 32'd1);
        req_valid = 2'b11;
        rst_n     = 1'b0;
        #1;
        check_eq("t5_valid", 32'(rsp_valid), 32'd0);
        check_eq("t5_cnt", 32'(grant_cnt), 32'd0);
        check_eq("t5_ready", 32'(req_ready), 32'd0);
        step();
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        set_req(0, 3'b010, 4'd4);
        #1;
        check_eq("t5_first_win", 32'(req_ready), 32'b01);
        step();
        check_eq("t5_id", 32'(rsp_id), 32'd0);
        check_eq("t5_data", 32'(rsp_data), 32'd200);

        // Count saturation: grant_cnt is 1 here, one accept per cycle from now on.
        req_valid = 2'b01;
        repeat (65533) step();
        check_eq("t6_cnt_fffe", 32'(grant_cnt), 32'hFFFE);
        step();
        check_eq("t6_cnt_ffff", 32'(grant_cnt), 32'hFFFF);
        repeat (3) step();
        check_eq("t6_cnt_sat", 32'(grant_cnt), 32'hFFFF);
        check_eq("t6_still_valid", 32'(rsp_valid), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
